sevseg_scan_arbiter: RTL and testbench

- Sequences the 4-digit multiplexed seven-segment display and shares it between two 16-bit requesters, for example the LFSR/register path and a CPU peripheral write.
- Performs round-robin arbitration with a minimum on-screen hold time.
- Drives anode scanning, leading-zero blanking and per-digit blink, and sits directly in front of the board pins.

---
 rtl/sevseg_pkg.sv | 36 +++
 rtl/sevseg_refresh_timer.sv | 54 +++++
 rtl/sevseg_scan_arbiter.sv | 126 ++++++++++++
 tb/tb_sevseg_scan_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevseg_pkg.sv
// Shared types, constants and the hex-to-segment decoder for the seven-segment scan arbiter.
package sevseg_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    localparam int NUM_DIGITS = 4;
    localparam logic [6:0] BLANK_SEG = 7'h7F;

    // Active-low segments ordered {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sevseg_refresh_timer.sv
// Digit-slot timer: refresh counter, scanned digit index, end-of-frame strobe and blink phase.
module sevseg_refresh_timer
    import sevseg_pkg::*;
#(
    parameter int REFRESH_DIV = 25000,
    parameter int BLINK_DIV   = 50
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx_o,
    output logic                          frame_end_o,
    output logic                          blink_phase_o
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);

    logic [RW-1:0] r_cnt;
    logic [IW-1:0] r_idx;
    logic [BW-1:0] r_blink_cnt;
    logic          r_phase;
    logic          w_tick;
    logic          w_frame_end;

    assign w_tick      = (r_cnt == RW'(REFRESH_DIV - 1));
    assign w_frame_end = w_tick && (r_idx == IW'(NUM_DIGITS - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + RW'(1);
            if (w_tick)
                r_idx <= r_idx + IW'(1);
            if (w_frame_end) begin
                if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
                    r_blink_cnt <= '0;
                    r_phase     <= ~r_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + BW'(1);
                end
            end
        end
    end

    assign digit_idx_o   = r_idx;
    assign frame_end_o   = w_frame_end;
    assign blink_phase_o = r_phase;

endmodule

// File: rtl/sevseg_scan_arbiter.sv
// Shares a 4-digit multiplexed display between two 16-bit requesters with round-robin
// arbitration and a minimum hold, then drives blanked/blinking anode and segment pins.
module sevseg_scan_arbiter
    import sevseg_pkg::*;
#(
    parameter int REFRESH_DIV = 25000,
    parameter int BLINK_DIV   = 50,
    parameter int MIN_HOLD    = 100
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    input  logic [15:0] req0_data_i,
    output logic        req0_ready_o,
    input  logic        req1_valid_i,
    input  logic [15:0] req1_data_i,
    output logic        req1_ready_o,
    input  logic        lzb_en_i,
    input  logic [3:0]  blink_mask_i,
    output logic        owner_o,
    output logic [15:0] data_o,
    output logic [3:0]  en_po,
    output logic [6:0]  seg_po
);

    localparam int HW = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;

    arb_state_t    r_state, w_state_nxt;
    logic [HW-1:0] r_hold;
    logic [15:0]   r_data;
    logic          r_owner;
    logic [1:0]    w_idx;
    logic          w_frame_end, w_phase;
    logic          w_grant, w_grant_vld;
    logic          w_rdy0, w_rdy1, w_xfer0, w_xfer1;
    logic [3:0]    w_lz, w_nib;
    logic          w_blank;

    sevseg_refresh_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLINK_DIV   (BLINK_DIV)
    ) u_timer (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .digit_idx_o   (w_idx),
        .frame_end_o   (w_frame_end),
        .blink_phase_o (w_phase)
    );

    assign w_grant_vld = req0_valid_i || req1_valid_i;
    assign w_grant     = (req0_valid_i && req1_valid_i) ? ~r_owner : req1_valid_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // In IDLE the granted requester is always valid, so a grant is also a transfer
    always_comb begin
        w_state_nxt = r_state;
        w_rdy0      = 1'b0;
        w_rdy1      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_vld) begin
                    w_rdy0 = ~w_grant;
                    w_rdy1 = w_grant;
                    if (MIN_HOLD > 0)
                        w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                w_rdy0 = ~r_owner;
                w_rdy1 = r_owner;
                if (w_frame_end && r_hold == HW'(1))
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign req0_ready_o = w_rdy0 && !rst_i;
    assign req1_ready_o = w_rdy1 && !rst_i;
    assign w_xfer0      = req0_valid_i && req0_ready_o;
    assign w_xfer1      = req1_valid_i && req1_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data  <= '0;
            r_owner <= 1'b0;
            r_hold  <= '0;
        end else begin
            if (w_xfer0)
                r_data <= req0_data_i;
            else if (w_xfer1)
                r_data <= req1_data_i;
            if (r_state == IDLE && (w_xfer0 || w_xfer1)) begin
                r_owner <= w_xfer1;
                r_hold  <= HW'(MIN_HOLD);
            end else if (r_state == HOLD && w_frame_end) begin
                r_hold <= r_hold - HW'(1);
            end
        end
    end

    assign w_lz[3] = (r_data[15:12] == 4'h0);
    assign w_lz[2] = w_lz[3] && (r_data[11:8] == 4'h0);
    assign w_lz[1] = w_lz[2] && (r_data[7:4] == 4'h0);
    assign w_lz[0] = 1'b0;
    assign w_nib   = r_data[{w_idx, 2'b00} +: 4];
    assign w_blank = (w_phase && blink_mask_i[w_idx]) || (lzb_en_i && w_lz[w_idx]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en_po  <= 4'b1111;
            seg_po <= BLANK_SEG;
        end else begin
            en_po  <= w_blank ? 4'b1111 : ~(4'b0001 << w_idx);
            seg_po <= w_blank ? BLANK_SEG : hex_to_seg(w_nib);
        end
    end

    assign owner_o = r_owner;
    assign data_o  = r_data;

endmodule

// File: tb/tb_sevseg_scan_arbiter.sv
// Scoreboard bench: a cycle model predicts readies, transfers and pin values; transfers
// are queued at the clock edge and compared against data_o/owner_o the following half cycle.
module tb_sevseg_scan_arbiter;

    localparam int RD = 4;
    localparam int BD = 2;
    localparam int MH = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v0, v1, rdy0, rdy1, lzb, owner;
    logic [15:0] d0, d1, dout;
    logic [3:0]  mask, en;
    logic [6:0]  seg;

    always #5 clk = ~clk;

    sevseg_scan_arbiter #(
        .REFRESH_DIV (RD),
        .BLINK_DIV   (BD),
        .MIN_HOLD    (MH)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req0_valid_i (v0),
        .req0_data_i  (d0),
        .req0_ready_o (rdy0),
        .req1_valid_i (v1),
        .req1_data_i  (d1),
        .req1_ready_o (rdy1),
        .lzb_en_i     (lzb),
        .blink_mask_i (mask),
        .owner_o      (owner),
        .data_o       (dout),
        .en_po        (en),
        .seg_po       (seg)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] d;
        logic        o;
    } xfer_t;
    xfer_t sb_q[$];

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state
    int          m_cnt, m_idx, m_bc, m_hold;
    bit          m_ph, m_in_hold, m_owner;
    logic [15:0] m_data;
    logic [3:0]  m_en;
    logic [6:0]  m_seg;

    function automatic bit exp_rdy(input int r);
        if (rst) return 1'b0;
        if (m_in_hold) return (m_owner == r[0]);
        if (r == 0) return v0 && (!v1 || m_owner);
        return v1 && (!v0 || !m_owner);
    endfunction

    function automatic bit lz_blank(input logic [15:0] d, input int idx);
        if (idx == 0) return 1'b0;
        for (int k = idx; k < 4; k++)
            if (d[k*4 +: 4] != 4'h0) return 1'b0;
        return 1'b1;
    endfunction

    initial forever begin
        bit fe, blank, x0, x1, was_hold;
        @(posedge clk or posedge rst);
        if (rst) begin
            m_cnt = 0; m_idx = 0; m_bc = 0; m_hold = 0;
            m_ph = 0; m_in_hold = 0; m_owner = 0;
            m_data = '0; m_en = 4'hF; m_seg = 7'h7F;
            sb_q.delete();
        end else begin
            blank = (m_ph && mask[m_idx]) || (lzb && lz_blank(m_data, m_idx));
            m_en  = blank ? 4'hF : (4'hF ^ (4'h1 << m_idx));
            m_seg = blank ? 7'h7F : seg_tab[m_data[m_idx*4 +: 4]];
            x0 = v0 && exp_rdy(0);
            x1 = v1 && exp_rdy(1);
            fe = (m_cnt == RD - 1) && (m_idx == 3);
            was_hold = m_in_hold;
            if (was_hold && fe) begin
                if (m_hold == 1) m_in_hold = 0;
                m_hold--;
            end
            if (x0 || x1) begin
                m_data = x0 ? d0 : d1;
                if (!was_hold) begin
                    m_owner   = x1;
                    m_hold    = MH;
                    m_in_hold = (MH > 0);
                end
                sb_q.push_back('{m_data, m_owner});
            end
            if (m_cnt == RD - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_cnt++;
            end
            if (fe) begin
                if (m_bc == BD - 1) begin
                    m_bc = 0;
                    m_ph = !m_ph;
                end else begin
                    m_bc++;
                end
            end
        end
    end

    // One clock: readies checked before the edge, pins and scoreboard on the next falling edge
    task automatic cyc();
        #1;
        check("ready0", rdy0, exp_rdy(0));
        check("ready1", rdy1, exp_rdy(1));
        @(negedge clk);
        check("en_po", en, m_en);
        check("seg_po", seg, m_seg);
        if (sb_q.size() > 0) begin
            xfer_t e;
            e = sb_q.pop_front();
            check("sb_data", dout, e.d);
            check("sb_owner", owner, e.o);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (m_in_hold && n < 200) begin
            cyc();
            n++;
        end
        check(tag, m_in_hold, 0);
    endtask

    initial begin
        int n, lit, c0, c3;
        logic [3:0]  prev_en;
        logic [15:0] prev_d;
        v0 = 0; v1 = 0; d0 = '0; d1 = '0; lzb = 0; mask = '0;

        // Reset state
        @(negedge clk);
        check("rst_en", en, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_data", dout, 16'h0);
        check("rst_owner", owner, 1'b0);
        check("rst_rdy0", rdy0, 1'b0);
        check("rst_rdy1", rdy1, 1'b0);

        // 1: free-running scan, then leading-zero blanking on 0x0000
        rst = 0;
        cyc();
        check("t1_first_en", en, 4'b1110);
        check("t1_first_seg", seg, 7'h40);
        repeat (15) cyc();
        lzb = 1;
        cyc();
        lit = 0;
        for (int i = 0; i < 16; i++) begin
            if (en != 4'hF) lit++;
            cyc();
        end
        check("t1_lzb_lit", lit, 4);

        // 2: first grant to req0
        v0 = 1; d0 = 16'h12AF;
        #1 check("t2_rdy0", rdy0, 1'b1);
        cyc();
        v0 = 0;
        check("t2_data", dout, 16'h12AF);
        check("t2_owner", owner, 1'b0);
        n = 0;
        prev_en = en;
        cyc();
        while (!(en == 4'b1110 && prev_en != 4'b1110) && n < 20) begin
            prev_en = en;
            cyc();
            n++;
        end
        check("t2_d0_seg", seg, 7'h0E);
        check("t2_hold_rdy0", rdy0, 1'b1);

        // 3: req1 blocked during hold, owner keeps writing
        v1 = 1; d1 = 16'hBEEF;
        v0 = 1; d0 = 16'h0042;
        #1 check("t3_rdy1_blocked", rdy1, 1'b0);
        cyc();
        v0 = 0;
        check("t3_data", dout, 16'h0042);
        lit = 0;
        prev_d = dout;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (prev_d == 16'h0042 && (en == 4'b0111 || en == 4'b1011)) lit++;
            prev_d = dout;
        end
        check("t3_lzb_hi_blank", lit, 0);
        n = 0;
        while (dout != 16'hBEEF && n < 100) begin
            cyc();
            n++;
        end
        check("t3_beef", dout, 16'hBEEF);
        check("t3_owner", owner, 1'b1);
        v1 = 0;

        // 4: round-robin alternation with both requesters valid
        wait_idle("t4_idle_timeout");
        v0 = 1; d0 = 16'h1111;
        v1 = 1; d1 = 16'h2222;
        #1 check("t4_rdy0", rdy0, 1'b1);
        check("t4_rdy1", rdy1, 1'b0);
        cyc();
        check("t4_owner0", owner, 1'b0);
        n = 0;
        while (owner != 1'b1 && n < 100) begin
            cyc();
            n++;
        end
        check("t4_owner1", owner, 1'b1);
        check("t4_data1", dout, 16'h2222);
        v0 = 0; v1 = 0;

        // 5: blink digit 3 of 0x8888 over eight frames aligned to a frame start
        wait_idle("t5_idle_timeout");
        lzb = 0; mask = 4'b1000;
        v0 = 1; d0 = 16'h8888;
        cyc();
        v0 = 0;
        n = 0;
        prev_en = en;
        cyc();
        while (!(en == 4'b1110 && prev_en != 4'b1110) && n < 40) begin
            prev_en = en;
            cyc();
            n++;
        end
        c0 = 0; c3 = 0;
        for (int i = 0; i < 128; i++) begin
            if (en == 4'b1110) c0++;
            if (en == 4'b0111) c3++;
            cyc();
        end
        check("t5_d0_lit", c0, 32);
        check("t5_d3_lit", c3, 16);
        mask = 4'b0000;

        // 6: reset during hold, then immediate grant to req1
        wait_idle("t6_idle_timeout");
        v1 = 1; d1 = 16'hABCD;
        cyc();
        cyc();
        rst = 1;
        #1;
        check("t6_rst_en", en, 4'hF);
        check("t6_rst_seg", seg, 7'h7F);
        check("t6_rst_data", dout, 16'h0);
        check("t6_rst_rdy1", rdy1, 1'b0);
        cyc();
        rst = 0;
        #1 check("t6_rdy1", rdy1, 1'b1);
        cyc();
        check("t6_data", dout, 16'hABCD);
        check("t6_owner", owner, 1'b1);
        v1 = 0;
        repeat (4) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
